// File: rtl/uart_rx_deframer_pkg.sv
// Shared UART framing definitions: receiver state encoding, bit-timing helpers
// and frame constants reused by the matching transmitter.
package uart_rx_deframer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

   localparam int unsigned DEF_DATA_BITS = 8;
   localparam int unsigned MIN_DATA_BITS = 5;
   localparam int unsigned MAX_DATA_BITS = 9;
   localparam int unsigned MIN_CPB       = 4;
   localparam logic        LINE_IDLE     = 1'b1;

   // Clock cycles per serial bit (integer divide).
   function automatic int unsigned calc_cpb(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / baud;
   endfunction

   // Offset from the start edge to the middle of the start bit.
   function automatic int unsigned calc_half(input int unsigned cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/uart_rx_deframer.sv
// Serial receive deframer: recovers start/data/stop frames from a filtered,
// synchronised idle-high line and strobes each good word or framing error.
module uart_rx_deframer
   import uart_rx_deframer_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD      = 115_200,
   parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_busy
);

   localparam int unsigned CPB   = calc_cpb(CLK_FREQ, BAUD);
   localparam int unsigned HALF  = calc_half(CPB);
   localparam int unsigned CNT_W = $clog2(CPB);
   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

   if (CPB < MIN_CPB) begin : g_cpb_check
      $error("uart_rx_deframer: CLK_FREQ/BAUD must be at least 4");
   end
   if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bits_check
      $error("uart_rx_deframer: DATA_BITS must be within 5..9");
   end

   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q, busy_d;

   // State register and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; every counting state clears its counter at terminal count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_rx != LINE_IDLE) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               cnt_d = '0;
               if (i_rx != LINE_IDLE) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_W'(CPB - 1)) begin
               cnt_d = '0;
               for (int unsigned b = 0; b < DATA_BITS; b++) begin
                  if (idx_q == IDX_W'(b)) shreg_d[b] = i_rx;
               end
               if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_W'(CPB - 1)) begin
               cnt_d = '0;
               if (i_rx == LINE_IDLE) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_BREAK: begin
            // A held-low line stays here so it cannot produce repeated errors.
            if (i_rx == LINE_IDLE) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer at CPB=16: stimulus pushes expected
// strobes (kind, word, cycle) and a negedge monitor pops and compares them.
module tb_uart_rx_deframer;

   localparam int unsigned CPB  = 16;
   localparam int unsigned HALF = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ferr;
   logic       busy;

   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic        is_err;
      logic [7:0]  data;
      int unsigned at;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [7:0] last_good = 8'h00;

   uart_rx_deframer #(
      .CLK_FREQ  (1_600_000),
      .BAUD      (100_000),
      .DATA_BITS (8)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_rx        (rx),
      .o_data      (data),
      .o_valid     (valid),
      .o_frame_err (ferr),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (valid === 1'b1 || ferr === 1'b1)) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: valid=%0b err=%0b data=0x%0h at cycle %0d expected none",
                     valid, ferr, data, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check("strobe_kind", {30'd0, valid, ferr}, mon_e.is_err ? 32'd1 : 32'd2);
            check("strobe_data", {24'd0, data}, {24'd0, mon_e.data});
            check("strobe_cycle", cyc, mon_e.at);
         end
      end
   end

   // Entered just after a negedge; returns at the negedge ending the stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bitlen);
      exp_t e;
      rx       = 1'b0;
      e.is_err = ~stop;
      e.data   = stop ? b : last_good;
      e.at     = cyc + 1 + HALF + 9 * CPB;
      sb_q.push_back(e);
      if (stop) last_good = b;
      repeat (bitlen) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (bitlen) @(negedge clk);
      end
      rx = stop;
      repeat (bitlen) @(negedge clk);
   endtask

   initial begin
      #(100_000 * 10);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  b2b[3];
      logic [7:0]  slow[3];
      logic [7:0]  abort_b;
      int unsigned t;

      rx    = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_ferr", {31'd0, ferr}, 32'd0);
      check("reset_data", {24'd0, data}, 32'h00);
      rst_n = 1'b1;

      repeat (200) @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_data", {24'd0, data}, 32'h00);

      send_frame(8'hA5, 1'b1, CPB);
      check("a5_data", {24'd0, data}, 32'hA5);
      check("a5_busy", {31'd0, busy}, 32'd0);
      repeat (20) @(negedge clk);

      // Glitch start: four low cycles, rejected at the mid-start sample.
      rx = 1'b0;
      t  = cyc + 1;
      repeat (4) @(negedge clk);
      check("glitch_busy_start", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      repeat (6) @(negedge clk);
      check("glitch_cycle", cyc, t + 9);
      check("glitch_idle", {31'd0, busy}, 32'd0);
      check("glitch_data", {24'd0, data}, 32'hA5);
      repeat (20) @(negedge clk);

      // Framing error followed by a long break.
      send_frame(8'h3C, 1'b0, CPB);
      repeat (100) @(negedge clk);
      check("break_busy", {31'd0, busy}, 32'd1);
      check("break_data", {24'd0, data}, 32'hA5);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      check("break_release", {31'd0, busy}, 32'd0);
      send_frame(8'h55, 1'b1, CPB);
      check("after_break_data", {24'd0, data}, 32'h55);
      repeat (20) @(negedge clk);

      b2b[0] = 8'h00;
      b2b[1] = 8'hFF;
      b2b[2] = 8'h81;
      foreach (b2b[i]) send_frame(b2b[i], 1'b1, CPB);
      check("b2b_last", {24'd0, data}, 32'h81);
      repeat (20) @(negedge clk);

      // A 17-cycle bit lands the stop sample in the final data bit,
      // so these words keep bit 7 high to remain valid frames.
      slow[0] = 8'hFF;
      slow[1] = 8'h81;
      slow[2] = 8'hC0;
      foreach (slow[i]) send_frame(slow[i], 1'b1, CPB + 1);
      check("slow_last", {24'd0, data}, 32'hC0);
      repeat (20) @(negedge clk);

      // Reset during data bit 4 of 0xC3.
      abort_b = 8'hC3;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = abort_b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = abort_b[4];
      repeat (HALF) @(negedge clk);
      check("abort_busy_data", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      rx    = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_data", {24'd0, data}, 32'h00);
      last_good = 8'h00;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      send_frame(8'h12, 1'b1, CPB);
      check("post_abort_data", {24'd0, data}, 32'h12);
      repeat (20) @(negedge clk);

      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
